// File: rtl/linebuf_ctrl_pkg.sv
// linebuf_ctrl_pkg: shared widths and FSM state type for the line-buffer controller
package linebuf_ctrl_pkg;
    localparam int LWIDTH = 16;
    localparam int DWIDTH = 8;
    typedef enum logic [1:0] {S_WAIT, S_FEED, S_DRAIN} state_t;
endpackage

// File: rtl/linebuf_ctrl_delay.sv
// linebuf_ctrl_delay: fixed-depth shift register aligning window status with the data pipe
module linebuf_ctrl_delay
    import linebuf_ctrl_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];
    // shift one stage per cycle, all stages cleared on reset
    always_ff @(posedge clk) begin
        if (xrst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end
    assign q = stage[DEPTH-1];
endmodule

// File: rtl/linebuf_ctrl.sv
// linebuf_ctrl: raster address generator and window-valid tracker for a line buffer
module linebuf_ctrl
    import linebuf_ctrl_pkg::*;
#(
    parameter int MAXLINE    = 5,
    parameter int MAXSIZE    = 32,
    parameter int PIPE_DELAY = 3
) (
    input  logic                          clk,
    input  logic                          xrst,
    input  logic                          req,
    input  logic [LWIDTH-1:0]             img_size,
    input  logic [LWIDTH-1:0]             fil_size,
    output logic                          ack,
    output logic                          buf_en,
    output logic [2*$clog2(MAXSIZE)-1:0]  img_addr,
    output logic                          out_valid,
    output logic [LWIDTH-1:0]             out_row,
    output logic [LWIDTH-1:0]             out_col,
    output logic                          done,
    output logic                          err
);
    localparam int AW = 2*$clog2(MAXSIZE);
    localparam int PW = 2*LWIDTH + 2;
    state_t            state;
    logic [LWIDTH-1:0] img_q, fil_q, row, col, edge_m1, fil_m1;
    logic              bad, at_last, win;
    logic [PW-1:0]     pin, pout;
    // request validation and status of the pixel issued this cycle
    always_comb begin
        bad     = fil_size == '0 || fil_size > LWIDTH'(MAXLINE) || img_size > LWIDTH'(MAXSIZE) || img_size < fil_size;
        edge_m1 = img_q - LWIDTH'(1);
        fil_m1  = fil_q - LWIDTH'(1);
        at_last = state == S_FEED && row == edge_m1 && col == edge_m1;
        win     = state == S_FEED && row >= fil_m1 && col >= fil_m1;
        pin     = {at_last, win, win ? row - fil_m1 : '0, win ? col - fil_m1 : '0};
    end
    // job sequencing: accept/reject, raster scan, then wait for the pipe to flush
    always_ff @(posedge clk) begin
        if (xrst) begin
            state    <= S_WAIT;
            buf_en   <= 1'b0;
            err      <= 1'b0;
            img_addr <= '0;
            row      <= '0;
            col      <= '0;
            img_q    <= '0;
            fil_q    <= '0;
        end else begin
            buf_en <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_WAIT: if (req) begin
                    if (bad) err <= 1'b1;
                    else begin
                        state    <= S_FEED;
                        buf_en   <= 1'b1;
                        img_addr <= '0;
                        row      <= '0;
                        col      <= '0;
                        img_q    <= img_size;
                        fil_q    <= fil_size;
                    end
                end
                S_FEED: if (at_last) state <= S_DRAIN;
                else begin
                    img_addr <= img_addr + AW'(1);
                    col      <= col == edge_m1 ? '0 : col + LWIDTH'(1);
                    row      <= col == edge_m1 ? row + LWIDTH'(1) : row;
                end
                S_DRAIN: if (done) state <= S_WAIT;
                default: state <= S_WAIT;
            endcase
        end
    end
    linebuf_ctrl_delay #(.DEPTH(PIPE_DELAY), .WIDTH(PW)) u_delay (
        .clk  (clk),
        .xrst (xrst),
        .d    (pin),
        .q    (pout)
    );
    assign {done, out_valid, out_row, out_col} = pout;
    assign ack = state == S_WAIT;
endmodule

// File: tb/tb_linebuf_ctrl.sv
// tb_linebuf_ctrl: directed checks of start, scan timing, rejection, abort and back-to-back jobs
module tb_linebuf_ctrl;
    localparam int PD = 3;
    logic        clk = 1'b0;
    logic        xrst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] img_size = '0;
    logic [15:0] fil_size = '0;
    logic        ack, buf_en, out_valid, done, err;
    logic [9:0]  img_addr;
    logic [15:0] out_row, out_col;
    int checks = 0;
    int errors = 0;

    linebuf_ctrl #(.MAXLINE(5), .MAXSIZE(32), .PIPE_DELAY(PD)) dut (
        .clk       (clk),
        .xrst      (xrst),
        .req       (req),
        .img_size  (img_size),
        .fil_size  (fil_size),
        .ack       (ack),
        .buf_en    (buf_en),
        .img_addr  (img_addr),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        xrst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack, buf_en, img_addr, out_valid, out_row, out_col, done, err} !== {1'b1, 1'b0, 10'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got ack=%b buf_en=%b addr=%0d v=%b r=%0d c=%0d done=%b err=%b exp ack=1 others 0",
                     ack, buf_en, img_addr, out_valid, out_row, out_col, done, err);
        end
        xrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_job(input int n, input int f, input int poke, input string nm);
        int k, cnt, er, ec, first_k, last_k, done_k, span, ea;
        span = n - f + 1;
        req = 1'b1; img_size = 16'(n); fil_size = 16'(f);
        @(negedge clk);
        k = 1;
        req = 1'b0;
        checks++;
        if ({buf_en, ack, img_addr} !== {1'b1, 1'b0, 10'd0}) begin
            errors++;
            $display("FAIL %s_start got buf_en=%b ack=%b addr=%0d exp 1 0 0", nm, buf_en, ack, img_addr);
        end
        cnt = 0; er = 0; ec = 0; first_k = -1; last_k = -1; done_k = -1;
        while (done_k < 0 && k < 4000) begin
            @(negedge clk);
            k++;
            if (k == poke) begin req = 1'b1; img_size = 16'd4; fil_size = 16'd2; end
            else if (k == poke + 1) req = 1'b0;
            ea = k <= n*n ? k - 1 : n*n - 1;
            checks++;
            if (buf_en !== 1'b0 || img_addr !== 10'(ea)) begin
                errors++;
                $display("FAIL %s_addr k=%0d got buf_en=%b addr=%0d exp 0 %0d", nm, k, buf_en, img_addr, ea);
            end
            if (out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                checks++;
                if (out_row !== 16'(er) || out_col !== 16'(ec)) begin
                    errors++;
                    $display("FAIL %s_coord k=%0d got (%0d,%0d) exp (%0d,%0d)", nm, k, out_row, out_col, er, ec);
                end
                cnt++;
                ec++;
                if (ec == span) begin ec = 0; er++; end
            end
            if (done === 1'b1) done_k = k;
        end
        req = 1'b0;
        checks++;
        if (done_k < 0) begin
            errors++;
            $display("FAIL %s_timeout got no done exp done within 4000 cycles", nm);
        end
        checks++;
        if (first_k != 1 + (f-1)*n + (f-1) + PD) begin
            errors++;
            $display("FAIL %s_first got %0d exp %0d", nm, first_k, 1 + (f-1)*n + (f-1) + PD);
        end
        checks++;
        if (last_k != n*n + PD || done_k != last_k) begin
            errors++;
            $display("FAIL %s_last got last=%0d done=%0d exp %0d", nm, last_k, done_k, n*n + PD);
        end
        checks++;
        if (cnt != span*span) begin
            errors++;
            $display("FAIL %s_count got %0d exp %0d", nm, cnt, span*span);
        end
        @(negedge clk);
        checks++;
        if ({ack, done, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL %s_idle got ack=%b done=%b v=%b exp 1 0 0", nm, ack, done, out_valid);
        end
    endtask

    task automatic test_reject(input int n, input int f);
        req = 1'b1; img_size = 16'(n); fil_size = 16'(f);
        @(negedge clk);
        req = 1'b0;
        checks++;
        if ({err, buf_en, ack} !== 3'b101) begin
            errors++;
            $display("FAIL reject_%0d_%0d got err=%b buf_en=%b ack=%b exp 1 0 1", n, f, err, buf_en, ack);
        end
        @(negedge clk);
        checks++;
        if ({err, buf_en, ack, done} !== 4'b0010) begin
            errors++;
            $display("FAIL reject_after_%0d_%0d got err=%b buf_en=%b ack=%b done=%b exp 0 0 1 0", n, f, err, buf_en, ack, done);
        end
    endtask

    task automatic test_reset_abort();
        int bad;
        req = 1'b1; img_size = 16'd8; fil_size = 16'd3;
        @(negedge clk);
        req = 1'b0;
        repeat (9) @(negedge clk);
        xrst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, buf_en, img_addr, out_valid, out_row, out_col, done, err} !== {1'b1, 1'b0, 10'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset got ack=%b buf_en=%b addr=%0d v=%b done=%b err=%b exp 1 0 0 0 0 0",
                     ack, buf_en, img_addr, out_valid, done, err);
        end
        xrst = 1'b0;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (done !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || ack !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet got %0d active cycles exp 0", bad);
        end
        run_job(8, 3, 0, "after_abort");
    endtask

    task automatic test_back_to_back();
        int k, cnt, done_k;
        req = 1'b1; img_size = 16'd4; fil_size = 16'd2;
        k = 0; cnt = 0; done_k = -1;
        while (done_k < 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) cnt++;
            if (done === 1'b1) done_k = k;
        end
        checks++;
        if (done_k != 16 + PD || cnt != 9) begin
            errors++;
            $display("FAIL b2b_first got done_k=%0d cnt=%0d exp %0d 9", done_k, cnt, 16 + PD);
        end
        @(negedge clk);
        checks++;
        if ({ack, buf_en, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_gap got ack=%b buf_en=%b v=%b exp 1 0 0", ack, buf_en, out_valid);
        end
        @(negedge clk);
        req = 1'b0;
        checks++;
        if ({ack, buf_en, out_valid, img_addr} !== {1'b0, 1'b1, 1'b0, 10'd0}) begin
            errors++;
            $display("FAIL b2b_second_start got ack=%b buf_en=%b v=%b addr=%0d exp 0 1 0 0", ack, buf_en, out_valid, img_addr);
        end
        k = 1; cnt = 0; done_k = -1;
        while (done_k < 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (out_valid === 1'b1) cnt++;
            if (done === 1'b1) done_k = k;
        end
        checks++;
        if (done_k != 16 + PD || cnt != 9) begin
            errors++;
            $display("FAIL b2b_second got done_k=%0d cnt=%0d exp %0d 9", done_k, cnt, 16 + PD);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        run_job(8, 3, 0, "job_8_3");
        run_job(5, 5, 0, "job_5_5");
        run_job(6, 1, 0, "job_6_1");
        test_reject(8, 6);
        test_reject(2, 3);
        test_reject(8, 0);
        test_reject(40, 3);
        run_job(8, 3, 5, "ignored_req");
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/linebuf_ctrl.md
LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

Interface
REQ-001 Parameter MAXLINE, default 5, is the maximum filter edge length supported by the attached line buffer.
REQ-002 Parameter MAXSIZE, default 32, is the maximum image edge length.
REQ-003 Parameter PIPE_DELAY, default 3, is the cycles from image-address issue to the window update it causes (memory read, input register, window shift).
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 xrst  input  1  reset; synchronous, active-high (1 = reset).
REQ-006 req  input  1  start request; sampled only while ack=1.
REQ-007 img_size  input  LWIDTH  image edge length; sampled on accepted req.
REQ-008 fil_size  input  LWIDTH  filter edge length; sampled on accepted req.
REQ-009 ack  output  1  high when idle and able to accept req.
REQ-010 buf_en  output  1  one-cycle start pulse to the line buffer.
REQ-011 img_addr  output  2*$clog2(MAXSIZE)  row-major image read address.
REQ-012 out_valid  output  1  the line-buffer window holds a complete fil_size x fil_size patch.
REQ-013 out_row, out_col  output  LWIDTH each  top-left coordinate of the valid window.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-016 The FSM SHALL have states S_WAIT, S_FEED, S_DRAIN; ack=1 only in S_WAIT.
REQ-017 req=1 in S_WAIT at cycle T SHALL latch img_size/fil_size, enter S_FEED at T+1, drive buf_en=1 at T+1 only, and issue img_addr=0 at T+1.
REQ-018 Requests with fil_size==0, fil_size>MAXLINE, img_size>MAXSIZE or img_size<fil_size SHALL be rejected: err=1 at T+1, state stays S_WAIT, no buf_en, no done.
REQ-019 In S_FEED, img_addr SHALL increment by 1 every cycle from 0 to img_size^2-1, with internal row/col counters wrapping col at img_size-1 to 0 and incrementing row.
REQ-020 After issuing address img_size^2-1, the FSM SHALL enter S_DRAIN, hold img_addr, and stay there until the pipeline empties (PIPE_DELAY cycles).
REQ-021 Pixel (r,c) issued at cycle t SHALL produce out_valid=1 at t+PIPE_DELAY iff r>=fil_size-1 and c>=fil_size-1, with out_row=r-(fil_size-1) and out_col=c-(fil_size-1).
REQ-022 Exactly (img_size-fil_size+1)^2 out_valid cycles SHALL occur per job.
REQ-023 done SHALL pulse coincident with the final out_valid; the FSM SHALL return to S_WAIT on the next cycle.
REQ-024 req while ack=0 SHALL be ignored, not queued; size input changes mid-job SHALL have no effect.
REQ-025 The valid flag and coordinates SHALL be delayed through a PIPE_DELAY-deep register pipeline; no combinational path from req to any output.

Reset
REQ-026 While xrst=1: state S_WAIT, ack=1, buf_en=0, img_addr=0, out_valid=0, out_row=out_col=0, done=0, err=0, and all pipeline stages cleared.
REQ-027 Reset asserted mid-job SHALL abort the job in the following cycle, with no done or err emitted for it.

Structure
REQ-028 LWIDTH, DWIDTH and the state enum type SHALL live in the shared renkon package header.
REQ-029 The delay pipeline SHALL be one sub-module, linebuf_ctrl_delay, parameterised by depth and width.

Verification
REQ-030 img_size=8, fil_size=3, req at T -> buf_en at T+1; first out_valid at T+22 with (0,0); last at T+67 with (5,5); done at T+67; 36 valid cycles.
REQ-031 img_size=5, fil_size=5 -> exactly one out_valid, coordinate (0,0), coincident with done.
REQ-032 fil_size=6 or img_size=2,fil_size=3 -> err pulse at T+1, no buf_en, ack stays 1.
REQ-033 req pulsed during S_FEED -> ignored; job output identical to the undisturbed run.
REQ-034 xrst asserted at T+10 of an 8/3 job -> all outputs at reset values from T+11; a new req after release runs a full correct job.
REQ-035 Back-to-back jobs (req held high) -> second buf_en one cycle after first done plus S_WAIT acceptance; no overlap of out_valid streams.
